ps_responder: RTL and testbench
===============================

PS_RESPONDER -- requirements
Module: ps_responder

Behavioural responder for the MMCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE), used as the far end for the phase-shift controller in simulation and in MMCM-less builds.

Interface
REQ-001 The block SHALL have parameter DONE_LATENCY, default 12, giving the number of clk cycles from psen sample to psdone; legal values are 2..255.
REQ-002 The block SHALL have parameter STEPS, default 560, giving the number of phase steps per output period; legal values are at least 2.
REQ-003 The block SHALL have parameter PHASE_W, default $clog2(STEPS), giving the width of the phase output.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-005 Port clk  in  1  clock; all logic samples on its rising edge.
REQ-006 Port aresetn  in  1  asynchronous active-low reset.
REQ-007 Port psen  in  1  one-cycle phase-shift request.
REQ-008 Port psincdec  in  1  shift direction, sampled with psen: 1 = increment, 0 = decrement.
REQ-009 Port psdone  out  1  one-cycle completion pulse.
REQ-010 Port phase  out  PHASE_W  current phase position, range 0..STEPS-1.
REQ-011 Port busy  out  1  high while a shift is outstanding.
REQ-012 Port overlap_err  out  1  sticky flag: psen was received while busy.
REQ-013 Port clr_err  in  1  synchronous clear of overlap_err.
REQ-014 Port done_cnt  out  16  count of completed shifts.

Function
REQ-015 The state machine SHALL have states IDLE, SHIFT and DONE, and SHALL be in IDLE after reset.
REQ-016 In IDLE with psen=1, the block SHALL latch psincdec, clear the latency counter, and enter SHIFT on the next edge.
REQ-017 In SHIFT, the latency counter SHALL increment every cycle; when it equals DONE_LATENCY-2 the state SHALL advance to DONE.
REQ-018 psdone SHALL be high for exactly the one cycle spent in DONE, which is cycle N+DONE_LATENCY when psen is sampled at edge N; DONE SHALL then return to IDLE unconditionally.
REQ-019 phase SHALL update on the same edge that enters DONE, so the new value is visible together with psdone.
REQ-020 Increment SHALL wrap from STEPS-1 to 0.
REQ-021 Decrement SHALL wrap from 0 to STEPS-1.
REQ-022 busy SHALL be high in SHIFT and DONE and low in IDLE; it is registered, not a combinational decode of psen.
REQ-023 psen while busy=1 (including the psdone cycle) SHALL be ignored, with no effect on state, direction, phase or latency.
REQ-024 psen while busy=1 SHALL set overlap_err on the next edge.
REQ-025 clr_err=1 SHALL clear overlap_err on the next edge; if an overlap occurs in the same cycle, set SHALL take priority.
REQ-026 done_cnt SHALL increment on the edge entering DONE and SHALL saturate at 16'hFFFF.
REQ-027 psincdec SHALL be don't-care when psen=0; a psincdec change during SHIFT SHALL NOT alter the latched direction.

Reset
REQ-028 While aresetn=0, the block SHALL immediately force: state IDLE, psdone 0, busy 0, phase 0, overlap_err 0, done_cnt 0, latency counter 0.
REQ-029 Reset asserted mid-shift SHALL abort the shift; no psdone SHALL be issued for it, and phase SHALL remain 0 after release.
REQ-030 The first psen SHALL be accepted on the first rising edge after aresetn deasserts.

Verification
REQ-031 A bench SHALL drive one psen with psincdec=1 at edge 10 (DONE_LATENCY=12) and check psdone high only in cycle 22, phase 0->1, busy high cycles 11..22, done_cnt=1.
REQ-032 A bench SHALL start at phase=0 and drive psen with psincdec=0, and check phase=559 at psdone; it SHALL then drive a further increment and check phase=0.
REQ-033 A bench SHALL drive a second psen 5 cycles after the first and a third psen in the psdone cycle, and check that only one psdone occurs, phase changes by 1, and overlap_err=1.
REQ-034 A bench SHALL assert clr_err and an overlapping psen in the same cycle and check overlap_err stays 1; it SHALL then assert clr_err alone and check overlap_err=0 on the next edge.
REQ-035 A bench SHALL assert aresetn=0 at cycle 6 of a shift and check that phase, busy, psdone and done_cnt are 0 immediately and that no psdone occurs after release.
REQ-036 A bench SHALL run 70000 back-to-back legal shifts and check done_cnt=16'hFFFF (saturated) and phase=70000 mod 560 = 0.

Source files
------------

// File: rtl/ps_responder.sv
// Behavioural far end of the MMCM dynamic phase-shift port (psen/psincdec/psdone).
// Each accepted psen moves phase by one step and answers with psdone DONE_LATENCY cycles later.
module ps_responder #(
    parameter int DONE_LATENCY = 12,
    parameter int STEPS        = 560,
    parameter int PHASE_W      = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               psen,
    input  logic               psincdec,
    input  logic               clr_err,
    output logic               psdone,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               overlap_err,
    output logic [15:0]        done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The edge that enters DONE is the (DONE_LATENCY-1)th after acceptance, so psdone
    // is seen in the DONE_LATENCY-th cycle counted from the sampling edge.
    localparam logic [7:0]         LAT_LAST  = 8'(DONE_LATENCY - 2);
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(STEPS - 1);

    state_t             state;
    logic               dir;
    logic [7:0]         lat_cnt;
    logic [PHASE_W-1:0] phase_next;

    always_comb begin
        phase_next = phase;
        if (dir) begin
            phase_next = (phase == PHASE_MAX) ? '0 : phase + PHASE_W'(1);
        end else begin
            phase_next = (phase == '0) ? PHASE_MAX : phase - PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            dir      <= 1'b0;
            lat_cnt  <= '0;
            psdone   <= 1'b0;
            busy     <= 1'b0;
            phase    <= '0;
            done_cnt <= '0;
        end else begin
            psdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (psen) begin
                        dir     <= psincdec;
                        lat_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT_LAST) begin
                        state  <= DONE;
                        psdone <= 1'b1;
                        phase  <= phase_next;
                        if (done_cnt != 16'hFFFF) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A request arriving while busy wins over a simultaneous clear so it is never lost.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overlap_err <= 1'b0;
        end else if (psen && busy) begin
            overlap_err <= 1'b1;
        end else if (clr_err) begin
            overlap_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps_responder.sv
// Scoreboard bench for ps_responder: stimulus pushes expected psdone responses,
// a negedge monitor pops and compares them whenever psdone is seen.
module tb_ps_responder;

    localparam int L     = 12;
    localparam int STEPS = 560;
    localparam int PW    = $clog2(STEPS);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          aresetn, psen, psincdec, clr_err;
    logic          psdone, busy, overlap_err;
    logic [PW-1:0] phase;
    logic [15:0]   done_cnt;

    logic          s_psen, s_psincdec, s_clr_err;
    logic          s_psdone, s_busy, s_overlap_err;
    logic [PW-1:0] s_phase;
    logic [15:0]   s_done_cnt;

    ps_responder #(.DONE_LATENCY(L), .STEPS(STEPS)) dut (
        .clk(clk), .aresetn(aresetn), .psen(psen), .psincdec(psincdec),
        .clr_err(clr_err), .psdone(psdone), .phase(phase), .busy(busy),
        .overlap_err(overlap_err), .done_cnt(done_cnt)
    );

    ps_responder #(.DONE_LATENCY(2), .STEPS(STEPS)) sat_dut (
        .clk(clk), .aresetn(aresetn), .psen(s_psen), .psincdec(s_psincdec),
        .clr_err(s_clr_err), .psdone(s_psdone), .phase(s_phase), .busy(s_busy),
        .overlap_err(s_overlap_err), .done_cnt(s_done_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int s_dones     = 0;
    int exp_phase   = 0;
    int exp_cnt     = 0;

    typedef struct {
        int ph;
        int cnt;
        int done_edge;
    } exp_t;

    exp_t sb[$];

    // cyc holds the number of the most recent rising edge; "cycle k" is the interval ending at edge k.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (s_psdone) s_dones <= s_dones + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, required, cyc);
        end
    endtask

    function automatic int nextPhase(input int p, input bit up);
        if (up) return (p == STEPS - 1) ? 0 : p + 1;
        return (p == 0) ? STEPS - 1 : p - 1;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (psdone) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_psdone: got psdone=1, expected 0 (edge %0d)", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("psdone_edge", cyc, e.done_edge);
                checkOutput("psdone_phase", int'(phase), e.ph);
                checkOutput("psdone_done_cnt", int'(done_cnt), e.cnt);
            end
        end
    end

    // Drives psen so that it is sampled on rising edge at_edge; accepted requests get a scoreboard entry.
    task automatic applyStimulus(input int at_edge, input bit up, input bit accept, input bit clr);
        if (cyc >= at_edge) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL stim_schedule: got edge %0d, expected before %0d", cyc, at_edge);
            return;
        end
        while (cyc != at_edge - 1) @(negedge clk);
        psen     = 1'b1;
        psincdec = up;
        clr_err  = clr;
        if (accept) begin
            exp_phase = nextPhase(exp_phase, up);
            exp_cnt   = exp_cnt + 1;
            sb.push_back('{exp_phase, exp_cnt, at_edge + L - 1});
        end
        @(posedge clk);
        #1;
        psen     = 1'b0;
        clr_err  = 1'b0;
        psincdec = ~up;
    endtask

    task automatic waitDrain();
        int g = 0;
        while (sb.size() != 0 && g < 4 * L) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_psdone: got %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int g;
        aresetn    = 1'b0;
        psen       = 1'b0;
        psincdec   = 1'b0;
        clr_err    = 1'b0;
        s_psen     = 1'b0;
        s_psincdec = 1'b1;
        s_clr_err  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_phase", int'(phase), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_psdone", int'(psdone), 0);
        checkOutput("reset_overlap", int'(overlap_err), 0);
        checkOutput("reset_done_cnt", int'(done_cnt), 0);
        aresetn = 1'b1;

        // Single increment sampled at edge 10: busy over cycles 11..22, psdone in cycle 22.
        while (cyc != 9) @(negedge clk);
        checkOutput("busy_before", int'(busy), 0);
        applyStimulus(10, 1'b1, 1'b1, 1'b0);
        for (int e = 10; e <= 22; e++) begin
            while (cyc != e) @(negedge clk);
            checkOutput("busy_window", int'(busy), (e <= 21) ? 1 : 0);
            if (e == 20) checkOutput("phase_before_done", int'(phase), 0);
            if (e == 22) checkOutput("psdone_width", int'(psdone), 0);
        end
        waitDrain();
        checkOutput("done_cnt_one", int'(done_cnt), 1);

        // Down to 0, wrap down to 559, then wrap up back to 0.
        applyStimulus(cyc + 2, 1'b0, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(cyc + 2, 1'b0, 1'b1, 1'b0);
        waitDrain();
        checkOutput("wrap_down", int'(phase), STEPS - 1);
        applyStimulus(cyc + 2, 1'b1, 1'b1, 1'b0);
        waitDrain();
        checkOutput("wrap_up", int'(phase), 0);

        // Overlapping requests mid-shift and in the psdone cycle are ignored.
        checkOutput("overlap_clear_start", int'(overlap_err), 0);
        n = cyc + 2;
        applyStimulus(n, 1'b1, 1'b1, 1'b0);
        applyStimulus(n + 5, 1'b0, 1'b0, 1'b0);
        checkOutput("overlap_set", int'(overlap_err), 1);
        applyStimulus(n + L, 1'b0, 1'b0, 1'b0);
        waitDrain();
        repeat (2 * L) @(negedge clk);
        checkOutput("overlap_phase", int'(phase), 1);
        checkOutput("overlap_sticky", int'(overlap_err), 1);
        checkOutput("overlap_done_cnt", int'(done_cnt), exp_cnt);
        checkOutput("overlap_idle", int'(busy), 0);

        // Clear alone, then set beats a simultaneous clear, then clear alone again.
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        checkOutput("clr_alone_1", int'(overlap_err), 0);
        n = cyc + 2;
        applyStimulus(n, 1'b1, 1'b1, 1'b0);
        applyStimulus(n + 2, 1'b0, 1'b0, 1'b1);
        checkOutput("set_beats_clr", int'(overlap_err), 1);
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        checkOutput("clr_alone_2", int'(overlap_err), 0);
        waitDrain();
        checkOutput("pre_reset_phase", int'(phase), 2);

        // Reset in cycle 6 of a shift aborts it.
        n = cyc + 2;
        applyStimulus(n, 1'b1, 1'b0, 1'b0);
        while (cyc != n + 5) @(negedge clk);
        aresetn = 1'b0;
        #1;
        checkOutput("abort_phase", int'(phase), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_psdone", int'(psdone), 0);
        checkOutput("abort_done_cnt", int'(done_cnt), 0);
        exp_phase = 0;
        exp_cnt   = 0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (2 * L) @(negedge clk);
        checkOutput("abort_phase_after", int'(phase), 0);
        checkOutput("abort_busy_after", int'(busy), 0);

        // First psen accepted on the first edge after reset release.
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        applyStimulus(cyc + 1, 1'b1, 1'b1, 1'b0);
        checkOutput("first_edge_busy", int'(busy), 1);
        waitDrain();
        checkOutput("first_edge_phase", int'(phase), 1);

        // 70000 back-to-back increments on the short-latency instance.
        @(negedge clk);
        s_psen = 1'b1;
        g = 0;
        while (s_dones < 70000 && g < 250000) begin
            @(negedge clk);
            g++;
        end
        s_psen = 1'b0;
        checkOutput("sat_shift_count", s_dones, 70000);
        repeat (4) @(negedge clk);
        checkOutput("sat_done_cnt", int'(s_done_cnt), 16'hFFFF);
        checkOutput("sat_phase", int'(s_phase), 0);
        checkOutput("sat_busy", int'(s_busy), 0);
        checkOutput("sat_no_extra", s_dones, 70000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
